digit_scan_mux: RTL and testbench

//  Time-multiplexes N BCD digits from the clock counters onto one shared 7-seg decoder.

---
 rtl/digit_scan_mux_pkg.sv | 20 ++
 rtl/digit_scan_mux_tick_gen.sv | 30 +++
 rtl/digit_scan_mux.sv | 127 ++++++++++++
 tb/tb_digit_scan_mux.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/digit_scan_mux_pkg.sv
// Shared constants and divider helpers for the digit scan multiplexer.
// The FSM codes stay plain localparams so legacy code that compares raw bits keeps working.
package digit_scan_mux_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    // Cycles each digit owns within one refresh frame.
    function automatic int slot_cycles(input int clk_hz, input int refresh_hz, input int n_digits);
        return clk_hz / (refresh_hz * n_digits);
    endfunction

    // Cycles between blink_phase toggles.
    function automatic int half_blink_cycles(input int clk_hz, input int blink_hz);
        return clk_hz / (2 * blink_hz);
    endfunction

endpackage

// File: rtl/digit_scan_mux_tick_gen.sv
// Free-running divider: tick is high for one cycle out of every DIV.
// The first tick arrives DIV cycles after rst is released.
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CW'(DIV - 1));

endmodule

// File: rtl/digit_scan_mux.sv
// Scans N BCD digits onto one shared 7-seg decoder with a blank gap before each digit,
// set-mode blinking and leading-zero blanking of the most significant digit.
module digit_scan_mux
    import digit_scan_mux_pkg::*;
#(
    parameter int                    N_DIGITS     = 6,
    parameter int                    CLK_HZ       = 50_000_000,
    parameter int                    REFRESH_HZ   = 1000,
    parameter int                    BLANK_CYCLES = 16,
    parameter int                    BLINK_HZ     = 2,
    parameter logic                  AN_ACTIVE    = 1'b0,
    parameter logic [N_DIGITS-1:0]   DP_MASK      = 6'b010100,
    parameter logic                  SEG_INV      = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   bcd_in,
    input  logic [N_DIGITS-1:0]     blink_mask,
    input  logic                    lz_blank,
    output logic [3:0]              digit_data,
    output logic [N_DIGITS-1:0]     an,
    output logic                    dp
);

    localparam int   SLOT       = slot_cycles(CLK_HZ, REFRESH_HZ, N_DIGITS);
    localparam int   HALF_BLINK = half_blink_cycles(CLK_HZ, BLINK_HZ);
    localparam int   CW         = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int   IW         = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic DP_ON      = SEG_INV;
    localparam logic DP_OFF     = ~SEG_INV;

    if (SLOT < 2 || BLANK_CYCLES >= SLOT) begin : g_bad_params
        $error("digit_scan_mux: slot too short for the requested blank gap");
    end

    logic [3:0] digits [N_DIGITS];

    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digits
        assign digits[gi] = bcd_in[4*gi +: 4];
    end

    logic                cnt_wrap;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [0:0]          state_q, state_d;
    logic                blink_phase_q, blink_phase_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [3:0]          digit_data_q, digit_data_d;
    logic                dp_q, dp_d;
    logic                blink_tick;
    logic [3:0]          next_digit;
    logic                slot_blank;
    logic [N_DIGITS-1:0] an_show;

    tick_gen #(
        .DIV (HALF_BLINK)
    ) u_blink_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (blink_tick)
    );

    always_comb begin
        cnt_wrap      = (cnt_q == CW'(SLOT - 1));
        cnt_d         = cnt_wrap ? '0 : cnt_q + CW'(1);
        idx_d         = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
        blink_phase_d = blink_tick ? ~blink_phase_q : blink_phase_q;

        // Digit and blanking are decided once, on the edge that opens the SHOW window.
        next_digit = digits[idx_d];
        slot_blank = (blink_mask[idx_d] && blink_phase_q)
                  || (lz_blank && (idx_d == IW'(N_DIGITS - 1)) && (next_digit == 4'd0));
        an_show        = {N_DIGITS{~AN_ACTIVE}};
        an_show[idx_d] = AN_ACTIVE;

        state_d      = state_q;
        an_d         = an_q;
        digit_data_d = digit_data_q;
        dp_d         = dp_q;

        if (cnt_d == CW'(BLANK_CYCLES)) begin
            state_d = ST_SHOW;
            if (slot_blank) begin
                an_d         = {N_DIGITS{~AN_ACTIVE}};
                digit_data_d = BLANK_CODE;
                dp_d         = DP_OFF;
            end else begin
                an_d         = an_show;
                digit_data_d = next_digit;
                dp_d         = DP_MASK[idx_d] ? DP_ON : DP_OFF;
            end
        end else if (state_q == ST_SHOW && cnt_d == '0) begin
            state_d      = ST_BLANK;
            an_d         = {N_DIGITS{~AN_ACTIVE}};
            digit_data_d = BLANK_CODE;
            dp_d         = DP_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            state_q       <= ST_BLANK;
            blink_phase_q <= 1'b0;
            an_q          <= {N_DIGITS{~AN_ACTIVE}};
            digit_data_q  <= BLANK_CODE;
            dp_q          <= DP_OFF;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            state_q       <= state_d;
            blink_phase_q <= blink_phase_d;
            an_q          <= an_d;
            digit_data_q  <= digit_data_d;
            dp_q          <= dp_d;
        end
    end

    assign an         = an_q;
    assign digit_data = digit_data_q;
    assign dp         = dp_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Directed bench for digit_scan_mux: slot expectations are queued when a digit is latched
// and compared every cycle of that slot.
module tb_digit_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] bcd_in;
    logic [5:0]  blink_mask;
    logic        lz_blank;
    logic [3:0]  digit_data;
    logic [5:0]  an;
    logic        dp;

    always #5 clk = ~clk;

    digit_scan_mux #(
        .N_DIGITS     (6),
        .CLK_HZ       (1200),
        .REFRESH_HZ   (10),
        .BLANK_CYCLES (4),
        .BLINK_HZ     (5),
        .AN_ACTIVE    (1'b0),
        .DP_MASK      (6'b010100),
        .SEG_INV      (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .blink_mask (blink_mask),
        .lz_blank   (lz_blank),
        .digit_data (digit_data),
        .an         (an),
        .dp         (dp)
    );

    typedef struct packed {
        logic [5:0] an;
        logic [3:0] data;
        logic       dp;
    } exp_t;

    localparam exp_t BLANK_EXP = '{an: 6'h3F, data: 4'hF, dp: 1'b1};

    exp_t sb_q[$];
    exp_t cur;
    int   e;
    int   n_vec;
    int   n_err;

    task automatic check(input string tag, input exp_t x);
        n_vec++;
        assert (an === x.an) else begin
            n_err++;
            $error("FAIL %s e=%0d an=%b expected %b", tag, e, an, x.an);
        end
        n_vec++;
        assert (digit_data === x.data) else begin
            n_err++;
            $error("FAIL %s e=%0d digit_data=%h expected %h", tag, e, digit_data, x.data);
        end
        n_vec++;
        assert (dp === x.dp) else begin
            n_err++;
            $error("FAIL %s e=%0d dp=%b expected %b", tag, e, dp, x.dp);
        end
    endtask

    // Expected outputs for the slot whose SHOW window opens at edge edge_i.
    // Slot length 20, frame 120, blink_phase flips every 120 edges from release.
    function automatic exp_t model_slot(input int edge_i);
        int         idx;
        logic [3:0] d;
        logic       ph;
        exp_t       r;
        idx = ((edge_i + 1) / 20) % 6;
        d   = bcd_in[idx*4 +: 4];
        ph  = ((edge_i / 120) % 2) == 1;
        if ((blink_mask[idx] && ph) || (lz_blank && idx == 5 && d == 4'd0)) begin
            r = BLANK_EXP;
        end else begin
            r.an      = 6'h3F;
            r.an[idx] = 1'b0;
            r.data    = d;
            r.dp      = (idx == 2 || idx == 4) ? 1'b0 : 1'b1;
        end
        return r;
    endfunction

    task automatic cyc(input string tag);
        if (((e + 1) % 20) == 4) sb_q.push_back(model_slot(e));
        @(posedge clk);
        #1;
        if (((e + 1) % 20) == 4) cur = sb_q.pop_front();
        if (((e + 1) % 20) >= 4) check(tag, cur);
        else                     check(tag, BLANK_EXP);
        $display("[%0t] %s e=%0d an=%b data=%h dp=%b", $time, tag, e, an, digit_data, dp);
        e++;
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag);
    endtask

    task automatic reset_cycles(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("reset", BLANK_EXP);
            $display("[%0t] reset an=%b data=%h dp=%b", $time, an, digit_data, dp);
        end
        rst = 1'b0;
        e   = 0;
        sb_q.delete();
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        e          = 0;
        cur        = BLANK_EXP;
        rst        = 1'b1;
        bcd_in     = 24'h123456;
        blink_mask = 6'b000000;
        lz_blank   = 1'b0;

        reset_cycles(3);
        run("scan", 240);

        // Change digit 0 while it is being shown.
        run("scan", 10);
        bcd_in = 24'h123459;
        run("notear", 240);

        blink_mask = 6'b000011;
        run("blink", 360);

        blink_mask = 6'b000000;
        lz_blank   = 1'b1;
        bcd_in     = 24'h012345;
        run("lz_zero", 240);
        bcd_in     = 24'h112345;
        run("lz_one", 120);
        lz_blank   = 1'b0;
        bcd_in     = 24'h012345;
        run("lz_off", 120);

        // Reach mid-SHOW of digit 3, then pulse reset with every digit blink-enabled.
        for (int i = 0; i < 200 && !(((e / 20) % 6) == 3 && (e % 20) == 10); i++) cyc("pre_rst");
        blink_mask = 6'b111111;
        reset_cycles(1);
        run("post_rst", 150);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
